// File: rtl/ms_timer_display.sv
// ms_timer_display: 1 kHz millisecond tick divided down from the system clock,
// a six-digit BCD elapsed-time counter shown as SSS.mmm, and active-low
// 7-segment drive for each digit.
module ms_timer_display #(
  parameter int unsigned CLK_DIV  = 50000,    // system clocks per millisecond
  parameter int unsigned MS_WRAP  = 1000000,  // ms count at which time returns to 0
  parameter logic [23:0] INIT_BCD = '0        // digit value loaded by reset, {d5..d0}
) (
  input  logic        clkIn,
  input  logic        rst,
  output logic        clkOut,
  output logic        msTick,
  output logic [29:0] timeOut,
  output logic [7:0]  hex5,
  output logic [7:0]  hex4,
  output logic [7:0]  hex3,
  output logic [7:0]  hex2,
  output logic [7:0]  hex1,
  output logic [7:0]  hex0
);

  localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);

  // Binary-to-BCD conversion of the last count before wrap, evaluated at elaboration.
  function automatic logic [23:0] to_bcd(input int unsigned v);
    logic [23:0] r;
    int unsigned t;
    r = '0;
    t = v;
    for (int unsigned i = 0; i < 6; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  localparam logic [23:0] WRAP_BCD = to_bcd(MS_WRAP - 1);

  // Active-low segment pattern {dp,g,f,e,d,c,b,a} for one {dp,bcd} field.
  function automatic logic [7:0] seg7(input logic [4:0] f);
    logic [6:0] p;
    case (f[3:0])
      4'h0:    p = 7'h40;
      4'h1:    p = 7'h79;
      4'h2:    p = 7'h24;
      4'h3:    p = 7'h30;
      4'h4:    p = 7'h19;
      4'h5:    p = 7'h12;
      4'h6:    p = 7'h02;
      4'h7:    p = 7'h78;
      4'h8:    p = 7'h00;
      4'h9:    p = 7'h10;
      4'hA:    p = 7'h08;
      4'hB:    p = 7'h03;
      4'hC:    p = 7'h46;
      4'hD:    p = 7'h21;
      4'hE:    p = 7'h06;
      default: p = 7'h0E;
    endcase
    return {~f[4], p};
  endfunction

  logic [DW-1:0] r_divCnt;
  logic          r_clkOut;
  logic          r_msTick;
  logic [23:0]   r_bcd;

  logic [DW-1:0] w_divNext;
  logic          w_tick;
  logic          w_wrap;
  logic [23:0]   w_bcdNext;

  assign w_tick    = (r_divCnt == DIV_LAST);
  assign w_divNext = w_tick ? '0 : r_divCnt + 1'b1;
  assign w_wrap    = (r_bcd == WRAP_BCD);

  // Divider; clkOut and msTick are registered from the next divider value so
  // they line up with the divCnt value they describe.
  always_ff @(posedge clkIn or posedge rst) begin
    if (rst) begin
      r_divCnt <= '0;
      r_clkOut <= 1'b0;
      r_msTick <= 1'b0;
    end else begin
      r_divCnt <= w_divNext;
      r_clkOut <= (w_divNext >= DIV_HALF);
      r_msTick <= (w_divNext == DIV_LAST);
    end
  end

  // Ripple BCD increment; any digit at 9 or above rolls to 0 so digits stay BCD.
  always_comb begin
    logic carry;
    w_bcdNext = r_bcd;
    carry     = 1'b1;
    for (int unsigned i = 0; i < 6; i++) begin
      if (carry) begin
        if (r_bcd[4*i +: 4] >= 4'd9) begin
          w_bcdNext[4*i +: 4] = '0;
        end else begin
          w_bcdNext[4*i +: 4] = r_bcd[4*i +: 4] + 4'd1;
          carry               = 1'b0;
        end
      end
    end
  end

  // Time digits advance on the edge that ends the msTick cycle; wrap has priority.
  always_ff @(posedge clkIn or posedge rst) begin
    if (rst) begin
      r_bcd <= INIT_BCD;
    end else if (w_tick) begin
      r_bcd <= w_wrap ? '0 : w_bcdNext;
    end
  end

  // Pack digits into {dp,bcd} fields; only digit 3 carries the decimal point.
  always_comb begin
    timeOut = '0;
    for (int unsigned n = 0; n < 6; n++) begin
      timeOut[5*n +: 5] = {(n == 3), r_bcd[4*n +: 4]};
    end
  end

  assign clkOut = r_clkOut;
  assign msTick = r_msTick;

  assign hex0 = seg7(timeOut[4:0]);
  assign hex1 = seg7(timeOut[9:5]);
  assign hex2 = seg7(timeOut[14:10]);
  assign hex3 = seg7(timeOut[19:15]);
  assign hex4 = seg7(timeOut[24:20]);
  assign hex5 = seg7(timeOut[29:25]);

endmodule

// File: tb/tb_ms_timer_display.sv
// Bench for ms_timer_display: full-rate instance for reset and first-tick
// behaviour, plus two fast instances (CLK_DIV=4) for carries, the 1 s point
// and the 999.999 -> 000.000 wrap, checked through a scoreboard.
module tb_ms_timer_display;

  localparam int unsigned MS_WRAP = 1000000;

  typedef struct {
    int unsigned ms;
    logic [29:0] to;
    logic [47:0] hx;
  } exp_t;

  logic clk;
  logic rst;
  logic sb_en;

  logic a_clk, a_tick, b_clk, b_tick, c_clk, c_tick;
  logic [29:0] a_to, b_to, c_to;
  wire  [47:0] a_hx, b_hx, c_hx;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  exp_t qB[$];
  exp_t qC[$];
  int unsigned cntB = 0;
  int unsigned cntC = 999998;
  int unsigned kB   = 0;
  bit sawB10, sawB100, sawB1000, sawC9, sawC0;

  ms_timer_display dutA (
    .clkIn(clk), .rst(rst), .clkOut(a_clk), .msTick(a_tick), .timeOut(a_to),
    .hex5(a_hx[47:40]), .hex4(a_hx[39:32]), .hex3(a_hx[31:24]),
    .hex2(a_hx[23:16]), .hex1(a_hx[15:8]), .hex0(a_hx[7:0])
  );

  ms_timer_display #(.CLK_DIV(4)) dutB (
    .clkIn(clk), .rst(rst), .clkOut(b_clk), .msTick(b_tick), .timeOut(b_to),
    .hex5(b_hx[47:40]), .hex4(b_hx[39:32]), .hex3(b_hx[31:24]),
    .hex2(b_hx[23:16]), .hex1(b_hx[15:8]), .hex0(b_hx[7:0])
  );

  ms_timer_display #(.CLK_DIV(4), .INIT_BCD(24'h999998)) dutC (
    .clkIn(clk), .rst(rst), .clkOut(c_clk), .msTick(c_tick), .timeOut(c_to),
    .hex5(c_hx[47:40]), .hex4(c_hx[39:32]), .hex3(c_hx[31:24]),
    .hex2(c_hx[23:16]), .hex1(c_hx[15:8]), .hex0(c_hx[7:0])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] segpat(input logic [3:0] d);
    case (d)
      4'd0: return 7'h40;
      4'd1: return 7'h79;
      4'd2: return 7'h24;
      4'd3: return 7'h30;
      4'd4: return 7'h19;
      4'd5: return 7'h12;
      4'd6: return 7'h02;
      4'd7: return 7'h78;
      4'd8: return 7'h00;
      4'd9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  // Expected display state for an elapsed-ms count, from integer arithmetic.
  function automatic exp_t mk(input int unsigned v);
    exp_t e;
    int unsigned t;
    logic [3:0] d;
    logic dp;
    e.ms = v;
    e.to = '0;
    e.hx = '0;
    t = v;
    for (int unsigned n = 0; n < 6; n++) begin
      d  = 4'(t % 10);
      t  = t / 10;
      dp = (n == 3);
      e.to[5*n +: 5] = {dp, d};
      e.hx[8*n +: 8] = {~dp, segpat(d)};
    end
    return e;
  endfunction

  // clkOut/msTick shape of the fast instance over its first three periods.
  always @(posedge clk) begin
    if (sb_en) begin
      #1;
      kB++;
      if (kB <= 12) begin
        chk("B_clkOut_shape", b_clk, ((kB % 4) >= 2));
        chk("B_msTick_shape", b_tick, ((kB % 4) == 3));
      end
    end
  end

  // Scoreboard for the fast instance starting at 0.
  always @(posedge clk) begin
    exp_t e;
    if (sb_en) begin
      #1;
      if (qB.size() > 0) begin
        e = qB.pop_front();
        chk("B_timeOut", b_to, e.to);
        chk("B_hex", b_hx, e.hx);
        if (e.ms == 10) begin
          chk("B_hex1_at_10ms", b_hx[15:8], 8'hF9);
          chk("B_hex0_at_10ms", b_hx[7:0], 8'hC0);
          sawB10 = 1'b1;
        end
        if (e.ms == 100) begin
          chk("B_hex2_at_100ms", b_hx[23:16], 8'hF9);
          chk("B_hex1_at_100ms", b_hx[15:8], 8'hC0);
          sawB100 = 1'b1;
        end
        if (e.ms == 1000) begin
          chk("B_hex_at_1s", b_hx, 48'hC0C079C0C0C0);
          sawB1000 = 1'b1;
        end
      end
      if (b_tick) begin
        cntB = (cntB + 1) % MS_WRAP;
        qB.push_back(mk(cntB));
      end
    end
  end

  // Scoreboard for the preloaded fast instance (wrap boundary).
  always @(posedge clk) begin
    exp_t e;
    if (sb_en) begin
      #1;
      if (qC.size() > 0) begin
        e = qC.pop_front();
        chk("C_timeOut", c_to, e.to);
        chk("C_hex", c_hx, e.hx);
        if (e.ms == 999999) begin
          chk("C_hex_at_999999", c_hx, 48'h909010909090);
          sawC9 = 1'b1;
        end
        if (e.ms == 0) begin
          chk("C_hex_after_wrap", c_hx, 48'hC0C040C0C0C0);
          chk("C_timeOut_after_wrap", c_to, 30'h80000);
          sawC0 = 1'b1;
        end
      end
      if (c_tick) begin
        cntC = (cntC + 1) % MS_WRAP;
        qC.push_back(mk(cntC));
      end
    end
  end

  initial begin
    int unsigned nA;
    rst   = 1'b1;
    sb_en = 1'b0;
    #3;
    chk("A_reset_timeOut", a_to, 30'h80000);
    chk("A_reset_hex", a_hx, 48'hC0C040C0C0C0);
    chk("A_reset_clkOut", a_clk, 1'b0);
    chk("A_reset_msTick", a_tick, 1'b0);

    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (19) begin
      @(posedge clk);
      #1;
    end
    chk("B_pre_reset_tick", b_tick, 1'b1);
    chk("B_pre_reset_clkOut", b_clk, 1'b1);
    chk("B_pre_reset_timeOut", b_to, 30'h80004);

    // Asynchronous reset mid-cycle, checked before any clock edge.
    #2;
    rst = 1'b1;
    #1;
    chk("B_async_timeOut", b_to, 30'h80000);
    chk("B_async_hex", b_hx, 48'hC0C040C0C0C0);
    chk("B_async_clkOut", b_clk, 1'b0);
    chk("B_async_msTick", b_tick, 1'b0);
    chk("A_async_hex0", a_hx[7:0], 8'hC0);
    chk("A_async_hex3", a_hx[31:24], 8'h40);

    @(negedge clk);
    @(negedge clk);
    cntB  = 0;
    cntC  = 999998;
    rst   = 1'b0;
    sb_en = 1'b1;

    nA = 0;
    for (int i = 1; i <= 49999; i++) begin
      @(posedge clk);
      #1;
      nA += a_tick;
      if (i == 24999) chk("A_clkOut_low_half", a_clk, 1'b0);
      if (i == 25000) chk("A_clkOut_high_half", a_clk, 1'b1);
    end
    chk("A_msTick_count", nA, 1);
    chk("A_first_msTick", a_tick, 1'b1);
    chk("A_hex0_before_tick", a_hx[7:0], 8'hC0);
    @(posedge clk);
    #1;
    chk("A_msTick_one_cycle", a_tick, 1'b0);
    chk("A_clkOut_after_tick", a_clk, 1'b0);
    chk("A_timeOut_1ms", a_to, 30'h80001);
    chk("A_hex_1ms", a_hx, 48'hC0C040C0C0F9);

    repeat (8) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    sb_en = 1'b0;
    #20;
    chk("B_tick_total", cntB, 12502);
    chk("B_queue_drained", qB.size(), 0);
    chk("C_queue_drained", qC.size(), 0);
    chk("B_saw_10ms", sawB10, 1'b1);
    chk("B_saw_100ms", sawB100, 1'b1);
    chk("B_saw_1s", sawB1000, 1'b1);
    chk("C_saw_999999", sawC9, 1'b1);
    chk("C_saw_wrap", sawC0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
